// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing one DMI target between several DMI masters,
// with one transaction in flight and a response timeout for hung targets.
module dmi_arbiter #(
    parameter int NumHosts   = 2,
    parameter int RspTimeout = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumHosts-1:0]    host_req_valid_i,
    output logic [NumHosts-1:0]    host_req_ready_o,
    input  logic [NumHosts*7-1:0]  host_req_addr_i,
    input  logic [NumHosts*2-1:0]  host_req_op_i,
    input  logic [NumHosts*32-1:0] host_req_data_i,
    output logic [NumHosts-1:0]    host_rsp_valid_o,
    input  logic [NumHosts-1:0]    host_rsp_ready_i,
    output logic [31:0]            host_rsp_data_o,
    output logic [1:0]             host_rsp_resp_o,
    input  logic [NumHosts-1:0]    host_dmi_rst_ni,
    output logic                   dmi_req_valid_o,
    input  logic                   dmi_req_ready_i,
    output logic [6:0]             dmi_req_addr_o,
    output logic [1:0]             dmi_req_op_o,
    output logic [31:0]            dmi_req_data_o,
    input  logic                   dmi_rsp_valid_i,
    output logic                   dmi_rsp_ready_o,
    input  logic [31:0]            dmi_rsp_data_i,
    input  logic [1:0]             dmi_rsp_resp_i,
    output logic                   dmi_rst_no
);
    localparam int GrantW = $clog2(NumHosts);
    localparam int CntW   = (RspTimeout > 0) ? $clog2(RspTimeout + 1) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StReq   = 2'd1;
    localparam logic [1:0] StRsp   = 2'd2;
    localparam logic [1:0] StDrain = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [GrantW-1:0] grant_q, prio_q, prio_next, gnt_idx;
    logic              gnt_found;
    logic [CntW-1:0]   cnt_q;
    logic              timed_out;
    logic              dmi_rst_q;
    logic [6:0]        addr_q, sel_addr;
    logic [1:0]        op_q, sel_op;
    logic [31:0]       data_q, sel_data;
    int                off, best_off;

    // Lowest rotated distance from prio_q among requesting hosts wins.
    always_comb begin
        best_off = NumHosts;
        off      = 0;
        gnt_idx  = '0;
        for (int i = 0; i < NumHosts; i++) begin
            off = (i >= int'(prio_q)) ? i - int'(prio_q) : i + NumHosts - int'(prio_q);
            if (host_req_valid_i[i] && off < best_off) begin
                best_off = off;
                gnt_idx  = GrantW'(i);
            end
        end
        gnt_found = (best_off < NumHosts);
    end

    always_comb begin
        sel_addr = '0;
        sel_op   = '0;
        sel_data = '0;
        for (int i = 0; i < NumHosts; i++) begin
            if (gnt_idx == GrantW'(i)) begin
                sel_addr = host_req_addr_i[7*i +: 7];
                sel_op   = host_req_op_i[2*i +: 2];
                sel_data = host_req_data_i[32*i +: 32];
            end
        end
    end

    assign prio_next = (grant_q == GrantW'(NumHosts - 1)) ? '0 : grant_q + 1'b1;
    assign timed_out = (RspTimeout != 0) && (cnt_q == CntW'(RspTimeout));

    always_comb begin
        state_d          = state_q;
        host_req_ready_o = '0;
        host_rsp_valid_o = '0;
        host_rsp_data_o  = '0;
        host_rsp_resp_o  = '0;
        dmi_req_valid_o  = 1'b0;
        dmi_rsp_ready_o  = 1'b0;
        case (state_q)
            StIdle: begin
                if (dmi_rst_q && gnt_found) begin
                    host_req_ready_o[gnt_idx] = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                dmi_req_valid_o = 1'b1;
                if (dmi_req_ready_i) state_d = StRsp;
            end
            StRsp: begin
                dmi_rsp_ready_o = host_rsp_ready_i[grant_q];
                if (dmi_rsp_valid_i) begin
                    host_rsp_valid_o[grant_q] = 1'b1;
                    host_rsp_data_o = dmi_rsp_data_i;
                    host_rsp_resp_o = dmi_rsp_resp_i;
                    if (host_rsp_ready_i[grant_q]) state_d = StIdle;
                end else if (timed_out) begin
                    // Synthesised failure; the real response is swallowed in DRAIN.
                    host_rsp_valid_o[grant_q] = 1'b1;
                    host_rsp_resp_o = 2'd2;
                    if (host_rsp_ready_i[grant_q]) state_d = StDrain;
                end else begin
                    host_rsp_data_o = dmi_rsp_data_i;
                    host_rsp_resp_o = dmi_rsp_resp_i;
                end
            end
            default: begin
                dmi_rsp_ready_o = 1'b1;
                if (dmi_rsp_valid_i) state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            prio_q    <= '0;
            cnt_q     <= '0;
            dmi_rst_q <= 1'b0;
            addr_q    <= '0;
            op_q      <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            dmi_rst_q <= &host_dmi_rst_ni;
            if (state_q == StIdle && state_d == StReq) begin
                grant_q <= gnt_idx;
                addr_q  <= sel_addr;
                op_q    <= sel_op;
                data_q  <= sel_data;
            end
            if (state_q == StRsp && state_d != StRsp) prio_q <= prio_next;
            if (state_q == StReq) begin
                cnt_q <= '0;
            end else if (state_q == StRsp && !dmi_rsp_valid_i && !timed_out) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign dmi_req_addr_o = addr_q;
    assign dmi_req_op_o   = op_q;
    assign dmi_req_data_o = data_q;
    assign dmi_rst_no     = dmi_rst_q;

endmodule

// File: doc/dmi_arbiter.md
Name: dmi_arbiter

Overview:
- Shares one Debug Module Interface (DMI) target port between NumHosts DMI masters, e.g. a DPI/TCP debug bridge and a JTAG DTM, in simulation top-levels and FPGA builds.
- Round-robin arbitration with exactly one transaction in flight; the response is routed back to the granting host only.
- A response timeout converts a hung target into a failed response so that no host stalls forever.

Parameters:
NumHosts, 2, number of DMI masters (>=2); GrantW = $clog2(NumHosts)
RspTimeout, 1024, max cycles in RSP awaiting dmi_rsp_valid_i; 0 disables timeout; counter width = $clog2(RspTimeout+1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
host_req_valid_i  in  NumHosts  per-host request valid
host_req_ready_o  out  NumHosts  per-host request accept
host_req_addr_i  in  NumHosts*7  per-host address, host i at [7i+:7]
host_req_op_i  in  NumHosts*2  per-host op (0 nop, 1 read, 2 write)
host_req_data_i  in  NumHosts*32  per-host write data
host_rsp_valid_o  out  NumHosts  per-host response valid
host_rsp_ready_i  in  NumHosts  per-host response accept
host_rsp_data_o  out  32  response data, shared by all hosts
host_rsp_resp_o  out  2  response code, shared (0 ok, 2 failed, 3 busy)
host_dmi_rst_ni  in  NumHosts  per-host DMI reset request, active low
dmi_req_valid_o  out  1  target request valid
dmi_req_ready_i  in  1  target request ready
dmi_req_addr_o  out  7  target address
dmi_req_op_o  out  2  target op
dmi_req_data_o  out  32  target write data
dmi_rsp_valid_i  in  1  target response valid
dmi_rsp_ready_o  out  1  target response ready
dmi_rsp_data_i  in  32  target response data
dmi_rsp_resp_i  in  2  target response code
dmi_rst_no  out  1  combined DMI reset to target, active low

Behaviour:
- Reset (rst_ni low, asynchronous):
  - FSM = IDLE; grant_q = 0; prio_q = 0; timeout counter = 0.
  - Request registers cleared; all outputs 0, including dmi_rst_no.
- dmi_rst_no is registered: each cycle it takes &host_dmi_rst_ni. It is first high one cycle after reset deasserts if all host inputs are high.
- FSM states: IDLE, REQ, RSP, DRAIN.
- IDLE:
  - If dmi_rst_no is 0, no grant is made.
  - Otherwise g = first i with host_req_valid_i[i] set, searching prio_q, prio_q+1, ... modulo NumHosts.
  - host_req_ready_o[g] = 1 combinationally in the same cycle; all other readys are 0.
  - On that edge: latch addr/op/data of host g, set grant_q = g, go to REQ.
  - No valid requests: stay in IDLE.
- REQ:
  - dmi_req_valid_o = 1 with the latched payload, held stable until dmi_req_ready_i is seen.
  - On dmi_req_ready_i: go to RSP and clear the timeout counter.
  - Minimum latency from host accept to target accept: 1 cycle.
- RSP:
  - dmi_rsp_ready_o = host_rsp_ready_i[grant_q].
  - host_rsp_valid_o[grant_q] = dmi_rsp_valid_i; data and resp pass through combinationally. Other hosts' valids are 0.
  - On dmi_rsp_valid_i & host_rsp_ready_i[grant_q]: go to IDLE and set prio_q = grant_q+1 mod NumHosts.
  - Otherwise the counter increments while dmi_rsp_valid_i is 0.
  - Timeout: when the counter reaches RspTimeout with RspTimeout != 0, the host sees host_rsp_valid_o = 1, data = 0, resp = 2. The state holds until the host accepts. Then go to DRAIN and update prio_q.
- DRAIN:
  - dmi_rsp_ready_o = 1; no host response is presented and no grants are made.
  - The first dmi_rsp_valid_i is discarded, then go to IDLE.
- Simultaneous events:
  - Target response and timeout in the same cycle: the target response wins; the counter stops while dmi_rsp_valid_i is high.
  - Requests from several hosts: exactly one grant per transaction; the losers' valids stay pending with no ready.
- host_req_ready_o is only ever asserted in IDLE, so at most one transaction is outstanding.
- An op of 0 (nop) is forwarded like any other op; the arbiter does not interpret ops.
- A host deasserting valid before ready violates its protocol; the arbiter makes no guarantee in that case.
- Reset mid-transaction drops the transaction. A late target response arriving after reset is accepted only if a later grant is in RSP; the target is expected to be reset together with the arbiter.

Test Plan:
- Single host: host0 reads addr 0x11; target ready at once and returns data 0xDEADBEEF, resp 0 after 3 cycles -> host0 rsp valid with 0xDEADBEEF/0; host1 rsp valid stays 0; the transaction takes 1 cycle in IDLE, 1 in REQ, 3+1 in RSP.
- Round-robin: both hosts hold valid continuously with writes 0xA and 0xB -> grants alternate 0,1,0,1 across 4 transactions; the target sees the matching data in order.
- Backpressure: dmi_req_ready_i held low 5 cycles, then host_rsp_ready_i low 4 cycles after the target response -> the target payload is stable for all 5 cycles; dmi_rsp_ready_o stays low until the host is ready; exactly one handshake on each side.
- Timeout: RspTimeout=8, target never responds -> host gets resp 2, data 0 after 8 RSP cycles. A target response injected later is swallowed in DRAIN, and the next request completes normally.
- DMI reset gating: host1 drives host_dmi_rst_ni low -> dmi_rst_no goes low 1 cycle later; a host0 request is not accepted until host1 releases, then it is granted.
- Async reset asserted during RSP -> all outputs 0 immediately, FSM in IDLE, prio_q = 0; the first post-reset request from host1 with host0 idle is granted correctly.
